fifo_rd_stream: RTL and testbench

- Read-side controller for the team's synchronous FIFO (`fifo`).
- Drives the FIFO's `rd_en` and accepts `rd_data` one clock later.
- Repackages the words as a valid/ready stream for downstream consumers.
- Holds a 3-entry prefetch buffer, so throughput is one word per cycle with no combinational path from `out_ready` to `fifo_rd_en`.
- Also counts completed transfers and supports a synchronous flush.

---
 rtl/fifo_rd_stream_pkg.sv | 14 +
 rtl/fifo_rd_stream_if.sv | 29 ++
 rtl/fifo_skid_buf.sv | 74 +++++++
 rtl/fifo_rd_stream.sv | 61 ++++++
 tb/tb_fifo_rd_stream.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// rtl/fifo_rd_stream_pkg.sv - shared constants and pointer helper for the FIFO read-side streamer
package fifo_rd_stream_pkg;

    localparam int BUF_DEPTH = 3;
    localparam int PTR_WIDTH = 2;

    typedef logic [PTR_WIDTH-1:0] idx_t;

    // Advance a circular buffer index, wrapping from the last slot back to 0.
    function automatic idx_t ptr_next(idx_t p);
        return (p == idx_t'(BUF_DEPTH - 1)) ? '0 : p + idx_t'(1);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - FIFO read port plus outgoing valid/ready stream
interface fifo_rd_stream_if #(
    parameter int data_width = 7
);
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [data_width-1:0] fifo_rd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [data_width-1:0] out_data;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        input  out_ready,
        output fifo_rd_en,
        output out_valid,
        output out_data
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        output out_ready,
        input  fifo_rd_en,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/fifo_skid_buf.sv
// rtl/fifo_skid_buf.sv - 3-entry circular register buffer with push/pop/clear
module fifo_skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int data_width = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic [data_width-1:0] push_data,
    input  logic                  pop,
    output idx_t                  count,
    output logic [data_width-1:0] head_data
);

    logic [data_width-1:0] mem [BUF_DEPTH];
    idx_t                  head;
    idx_t                  tail;

    // Storage, pointers and occupancy; clear wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                for (int i = 0; i < BUF_DEPTH; i++) begin
                    if (tail == idx_t'(i)) begin
                        mem[i] <= push_data;
                    end
                end
                tail <= ptr_next(tail);
            end
            if (pop) begin
                head <= ptr_next(head);
            end
            if (push && !pop) begin
                count <= count + idx_t'(1);
            end else if (pop && !push) begin
                count <= count - idx_t'(1);
            end
        end
    end

    // Head word select; pointers never reach 3, so slot 0 doubles as the default.
    always_comb begin
        head_data = mem[0];
        for (int i = 1; i < BUF_DEPTH; i++) begin
            if (head == idx_t'(i)) begin
                head_data = mem[i];
            end
        end
    end

    // The issue rule upstream must keep occupancy within the three slots.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !clear && count == idx_t'(BUF_DEPTH)));

    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        count <= idx_t'(BUF_DEPTH));

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && count == '0));

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side controller repackaging words as a valid/ready stream
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int data_width = 7,
    parameter int cnt_width  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    fifo_rd_stream_if.master     bus,
    output logic [cnt_width-1:0] xfer_cnt
);

    logic       pend;
    idx_t       count;
    logic       push;
    logic       pop;
    logic [2:0] demand;

    // Entries held plus the word still in flight; reads stop once that fills the buffer,
    // which keeps out_ready out of the read-strobe path.
    assign demand         = {1'b0, count} + {2'b00, pend};
    assign bus.fifo_rd_en = rst_n && !bus.fifo_empty && !flush && (demand < 3'(BUF_DEPTH));

    assign bus.out_valid = (count != '0);
    assign pop           = bus.out_valid && bus.out_ready;
    assign push          = pend && !flush;

    fifo_skid_buf #(
        .data_width (data_width)
    ) u_skid_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (push),
        .push_data (bus.fifo_rd_data),
        .pop       (pop),
        .count     (count),
        .head_data (bus.out_data)
    );

    // A read issued this cycle returns data next cycle; flush already blocks the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
        end else begin
            pend <= bus.fifo_rd_en;
        end
    end

    // Completed handshakes, wrapping; a flush does not clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (pop) begin
            xfer_cnt <= xfer_cnt + cnt_width'(1);
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - randomized self-checking bench for fifo_rd_stream
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        fifo_empty;
    logic [6:0]  fifo_rd_data;
    logic        out_ready;
    logic [15:0] xfer_cnt;
    logic [3:0]  xfer_cnt4;

    fifo_rd_stream_if #(.data_width(7)) bus0 ();
    fifo_rd_stream_if #(.data_width(7)) bus4 ();

    assign bus0.fifo_empty   = fifo_empty;
    assign bus0.fifo_rd_data = fifo_rd_data;
    assign bus0.out_ready    = out_ready;
    assign bus4.fifo_empty   = fifo_empty;
    assign bus4.fifo_rd_data = fifo_rd_data;
    assign bus4.out_ready    = out_ready;

    fifo_rd_stream #(.data_width(7), .cnt_width(16)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus0),
        .xfer_cnt (xfer_cnt)
    );

    fifo_rd_stream #(.data_width(7), .cnt_width(4)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus4),
        .xfer_cnt (xfer_cnt4)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [6:0] fq[$];
    logic [6:0] exp_q[$];
    int         n_xfer = 0;
    bit         just_read = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        exp_q.delete();
        n_xfer     = 0;
        just_read  = 1'b0;
        fifo_empty = 1'b1;
    endtask

    task automatic load_word(input logic [6:0] v);
        fq.push_back(v);
        fifo_empty = 1'b0;
    endtask

    task automatic load(input int n, input int base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            load_word(rnd ? 7'($urandom) : 7'(base + i));
        end
    endtask

    task automatic step(output bit rd, output bit hs);
        bit exp_rd;
        bit exp_valid;
        int held;
        #1;
        held      = exp_q.size() - (just_read ? 1 : 0);
        exp_rd    = rst_n && !fifo_empty && !flush && (exp_q.size() < 3);
        exp_valid = (held > 0);
        check("rd_en", bus0.fifo_rd_en, exp_rd);
        check("rd_en_w4", bus4.fifo_rd_en, exp_rd);
        check("out_valid", bus0.out_valid, exp_valid);
        check("out_valid_w4", bus4.out_valid, exp_valid);
        if (exp_valid) begin
            check("out_data", bus0.out_data, exp_q[0]);
            check("out_data_w4", bus4.out_data, exp_q[0]);
        end
        check("xfer_cnt", xfer_cnt, n_xfer & 32'hFFFF);
        check("xfer_cnt_w4", xfer_cnt4, n_xfer & 32'hF);
        rd = bus0.fifo_rd_en;
        hs = bus0.out_valid && out_ready;
        @(posedge clk);
        @(negedge clk);
        if (hs) begin
            n_xfer++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (flush) exp_q.delete();
        if (rd && fq.size() > 0) begin
            fifo_rd_data = fq.pop_front();
            exp_q.push_back(fifo_rd_data);
        end else begin
            fifo_rd_data = 7'($urandom);
        end
        just_read  = rd;
        fifo_empty = (fq.size() == 0);
    endtask

    bit         rd;
    bit         hs;
    int         first;
    int         k;
    int         n_rd;
    int         saved;
    logic [6:0] d;
    logic [6:0] t3_vals [4];

    initial begin
        rst_n        = 1'b1;
        flush        = 1'b0;
        out_ready    = 1'b0;
        fifo_empty   = 1'b0;
        fifo_rd_data = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid", bus0.out_valid, 0);
        check("rst_rd_en", bus0.fifo_rd_en, 0);
        check("rst_xfer", xfer_cnt, 0);
        check("rst_data", bus0.out_data, 0);
        model_reset();
        @(negedge clk);
        step(rd, hs);
        rst_n = 1'b1;

        // Streaming at full rate: first word two cycles after the first read.
        out_ready = 1'b1;
        load(10, 0, 1'b0);
        first = -1;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            step(rd, hs);
            if (rd && first < 0) first = i;
            if (hs) begin
                check("t1_slot", i, first + 2 + k);
                k++;
            end
        end
        check("t1_count", k, 10);
        check("t1_xfer", xfer_cnt, 10);

        // Backpressure: only three reads, head word held.
        out_ready = 1'b0;
        load(10, 0, 1'b0);
        n_rd = 0;
        for (int i = 0; i < 8; i++) begin
            step(rd, hs);
            if (rd) n_rd++;
        end
        check("t2_reads", n_rd, 3);
        check("t2_head", bus0.out_data, 0);
        check("t2_valid", bus0.out_valid, 1);
        out_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            d = bus0.out_data;
            step(rd, hs);
            if (hs) begin
                check("t2_order", d, k);
                k++;
            end
        end
        check("t2_count", k, 10);

        // Alternating ready.
        t3_vals[0] = 7'd88;
        t3_vals[1] = 7'd11;
        t3_vals[2] = 7'd12;
        t3_vals[3] = 7'd33;
        for (int i = 0; i < 4; i++) load_word(t3_vals[i]);
        k = 0;
        for (int i = 0; i < 14; i++) begin
            out_ready = (i % 2 == 0);
            d = bus0.out_data;
            step(rd, hs);
            if (hs && k < 4) begin
                check("t3_order", d, t3_vals[k]);
                k++;
            end
        end
        check("t3_count", k, 4);

        // Flush with two held and one in flight.
        out_ready = 1'b0;
        load(6, 0, 1'b0);
        for (int i = 0; i < 3; i++) step(rd, hs);
        saved = n_xfer;
        flush = 1'b1;
        step(rd, hs);
        flush = 1'b0;
        check("t4_valid", bus0.out_valid, 0);
        check("t4_xfer", xfer_cnt, saved);
        out_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            d = bus0.out_data;
            step(rd, hs);
            if (hs) begin
                if (k == 0) check("t4_next", d, 3);
                k++;
            end
        end
        check("t4_count", k, 3);

        // Empty FIFO, then a single word.
        n_rd = 0;
        for (int i = 0; i < 6; i++) begin
            step(rd, hs);
            if (rd) n_rd++;
        end
        check("t5_reads", n_rd, 0);
        check("t5_idle", bus0.out_valid, 0);
        out_ready = 1'b0;
        load_word(7'd7);
        step(rd, hs);
        check("t5_valid_p1", bus0.out_valid, 0);
        step(rd, hs);
        check("t5_valid_p2", bus0.out_valid, 1);
        check("t5_data", bus0.out_data, 7);

        // Narrow counter wrap.
        rst_n = 1'b0;
        model_reset();
        step(rd, hs);
        rst_n = 1'b1;
        out_ready = 1'b1;
        load(17, 0, 1'b1);
        for (int i = 0; i < 25; i++) step(rd, hs);
        check("t6_xfer4", xfer_cnt4, 1);
        check("t6_xfer16", xfer_cnt, 17);

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 2) == 0 && fq.size() < 12) load($urandom_range(1, 4), 0, 1'b1);
            step(rd, hs);
        end
        flush = 1'b0;

        // Reset mid-stream.
        out_ready = 1'b1;
        load(8, 0, 1'b1);
        for (int i = 0; i < 4; i++) step(rd, hs);
        rst_n = 1'b0;
        #1;
        check("t7_valid", bus0.out_valid, 0);
        check("t7_rd_en", bus0.fifo_rd_en, 0);
        check("t7_xfer", xfer_cnt, 0);
        check("t7_data", bus0.out_data, 0);
        model_reset();
        step(rd, hs);
        step(rd, hs);
        rst_n = 1'b1;
        load(3, 40, 1'b0);
        for (int i = 0; i < 8; i++) step(rd, hs);
        check("t7_after", xfer_cnt, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
